// File: rtl/fp32_ieee_pack_stream.sv
// Two-stage valid/ready stage packing 34-bit internal floats into IEEE-754 binary32 words with sticky flags.
// Build option: define FP32_PACK_FTZ_EN to flush subnormal inputs to signed zero.
module fp32_ieee_pack_stream (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [33:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  flags,
  input  logic        flags_clr
);

  localparam int unsigned OUT_W  = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned FLAG_W = 3;

  localparam logic [OUT_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_PASS = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

  logic              v1_q, v1_d;
  logic [OUT_W-1:0]  d1_q, d1_d;
  cls_e              cls1_q, cls1_d;
  logic              v2_q, v2_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [FLAG_W-1:0] fl2_q, fl2_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  logic              adv1, adv2;
  cls_e              cls_in;
  logic [OUT_W-1:0]  pk;
  logic [FLAG_W-1:0] pk_fl;
  logic              s1_sign;
  logic [EXP_W-1:0]  s1_exp;
  logic [FRAC_W-1:0] s1_frac;

  // Handshake, class decode, packing and flag accumulation
  always_comb begin
    adv2    = !v2_q | out_ready;
    adv1    = !v1_q | adv2;
    cls_in  = CLS_NAN;
    pk      = '0;
    pk_fl   = '0;
    v1_d    = v1_q;
    d1_d    = d1_q;
    cls1_d  = cls1_q;
    v2_d    = v2_q;
    out_d   = out_q;
    fl2_d   = fl2_q;
    flags_d = flags_q;
    s1_sign = d1_q[31];
    s1_exp  = d1_q[30:23];
    s1_frac = d1_q[22:0];

    case (in_data[33:32])
      2'b00:   cls_in = CLS_ZERO;
      2'b01:   cls_in = (in_data[30:23] == 8'hFF) ? CLS_INF : CLS_PASS;
      2'b10:   cls_in = CLS_INF;
      default: cls_in = CLS_NAN;
    endcase

    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        d1_d   = in_data[31:0];
        cls1_d = cls_in;
      end
    end

    case (cls1_q)
      CLS_ZERO: pk = {s1_sign, 31'b0};
      CLS_PASS: begin
        pk = d1_q;
        if (s1_exp == '0 && s1_frac != '0) begin
          pk_fl[2] = 1'b1;
`ifdef FP32_PACK_FTZ_EN
          pk = {s1_sign, 31'b0};
`endif
        end
      end
      CLS_INF: begin
        pk       = {s1_sign, 8'hFF, 23'b0};
        pk_fl[1] = 1'b1;
      end
      default: begin
        pk       = QNAN;
        pk_fl[0] = 1'b1;
      end
    endcase

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        out_d = pk;
        fl2_d = pk_fl;
      end
    end

    // Clear takes priority over a same-cycle flagging transfer
    if (flags_clr)
      flags_d = '0;
    else if (v2_q && out_ready)
      flags_d = flags_q | fl2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      d1_q    <= '0;
      cls1_q  <= CLS_ZERO;
      v2_q    <= 1'b0;
      out_q   <= '0;
      fl2_q   <= '0;
      flags_q <= '0;
    end else begin
      v1_q    <= v1_d;
      d1_q    <= d1_d;
      cls1_q  <= cls1_d;
      v2_q    <= v2_d;
      out_q   <= out_d;
      fl2_q   <= fl2_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign out_data  = out_q;
  assign flags     = flags_q;

endmodule

// File: doc/fp32_ieee_pack_stream.md
# fp32_ieee_pack_stream

Streaming output stage placed directly downstream of the fp32 activation units (`relu_fp32`, `leakyrelu_fp32`). It accepts 34-bit internal floats (2-bit exception class + IEEE-style sign/exponent/fraction) and emits packed IEEE-754 binary32 words for memory or an external interface. The pipeline has two stages and a valid/ready handshake with full throughput and backpressure. It also keeps sticky exception flags for software.

## Interface
- No parameters. Widths are fixed: 34-bit input, 32-bit output.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — `in_data` is valid.
- `in_ready`  out  1  — the stage accepts `in_data` this cycle.
- `in_data`  in  34  — internal format, bit fields:
  - [33:32] exn: 00 zero, 01 normal, 10 inf, 11 NaN.
  - [31] sign.
  - [30:23] exponent.
  - [22:0] fraction.
- `out_valid`  out  1  — `out_data` is valid.
- `out_ready`  in  1  — the consumer accepts `out_data`.
- `out_data`  out  32  — IEEE-754 binary32.
- `flags`  out  3  — sticky flags:
  - [0] NaN seen.
  - [1] overflow (inf input or exponent-255 normal).
  - [2] underflow (normal input with exponent 0 and non-zero fraction).
- `flags_clr`  in  1  — clears `flags` on the next edge.

## Operation
- Conversion per exception class:
  - exn 00: `{sign, 31'b0}`. Signed zero is preserved.
  - exn 01 with exponent in 1..254: `in_data[31:0]` passes through bit-exact.
  - exn 01 with exponent 0: the low 32 bits pass through as an IEEE subnormal or zero. Underflow is flagged when the fraction is non-zero.
  - exn 01 with exponent 255: `{sign, 8'hFF, 23'b0}`. Overflow flag is set.
  - exn 10: `{sign, 8'hFF, 23'b0}`. Overflow flag is set.
  - exn 11: canonical quiet NaN `32'h7FC00000`. Sign and payload are discarded. NaN flag is set.
- Stage 1 (S1) registers the input and a 2-bit class decode. Stage 2 (S2) registers the packed word and its flag contributions.
- Advance rules:
  - `adv2 = !v2 | out_ready`.
  - `adv1 = !v1 | adv2`.
  - `in_ready = adv1`. This is combinational from `out_ready` and the stage valids only, never from `in_valid`.
- Transfers:
  - An input transfer happens when `in_valid & in_ready`.
  - An output transfer happens when `out_valid & out_ready`.
  - `out_valid = v2`.
- While stalled (`v2 & !out_ready`), `out_data` and `out_valid` hold stable.
- Flags:
  - `flags` ORs in S2's flag bits at the moment of the output transfer. Items that have not been consumed do not set flags.
  - If `flags_clr` and a flagging transfer occur in the same cycle, clear wins and the new bits are lost. This is a documented single-cycle priority.
- Ordering is strict FIFO. The stage never drops or duplicates an item.

## Timing
- Latency: 2 cycles from input transfer to `out_valid` when unstalled.
- Throughput: one item per cycle.
- Capacity: at most 2 items in flight.
- With `out_ready` held low, two items are accepted. `in_ready` falls on the cycle after the second acceptance.
- Reset values: `v1 = v2 = 0`, `out_valid = 0`, `out_data = 32'h0`, `flags = 3'b000`, `in_ready = 1`.
- Reset mid-operation discards all in-flight items with no output transfer. Flags clear.
- Simultaneous input transfer and output transfer with both stages full: S2 takes S1, S1 takes the input, and occupancy is unchanged.

## Configuration
- `FP32_PACK_FTZ_EN`
  - Defined: an exn-01 input with exponent 0 and non-zero fraction outputs `{sign, 31'b0}` (flush-to-zero). The underflow flag is still set.
  - Undefined: the subnormal passes through bit-exact as described under Operation.
- All other behaviour is identical in both builds.

## Test plan
- Class mapping, streaming back-to-back with `out_ready = 1`:
  - `34'h13f800000` → `32'h3f800000`.
  - `34'h1bf800000` → `32'hbf800000`.
  - `34'h080000000` → `32'h80000000`.
  - Each output appears exactly 2 cycles after its input transfer. `flags` stays `000`.
- Exceptions:
  - `34'h300000001` → `32'h7fc00000`, `flags[0] = 1`.
  - `34'h27f800000` → `32'h7f800000`, `flags[1] = 1`.
  - `34'h17f812345` → `32'h7f800000`.
  - `flags_clr` then returns `flags` to `000`.
- Subnormal:
  - `34'h100000001`: without the FTZ macro → `32'h00000001`, `flags[2] = 1`.
  - Same input with `FP32_PACK_FTZ_EN` → `32'h00000000`, `flags[2] = 1`.
  - `34'h100000000` → `32'h00000000` in both builds, `flags[2] = 0`.
- Backpressure:
  - Hold `out_ready = 0` and offer `34'h13f800000`, `34'h140000000`, `34'h140400000`.
  - The first two are accepted, then `in_ready = 0` and the third is held.
  - `out_data` stays `32'h3f800000` while stalled.
  - Raise `out_ready`: outputs `3f800000`, `40000000`, `40400000` in order on consecutive cycles.
- Reset mid-operation: with 2 items in flight and stalled, assert `rst` for 1 cycle. Then `out_valid = 0`, `in_ready = 1`, `flags = 000`, and no stale item ever emerges.
- Clear priority: assert `flags_clr` in the same cycle as a NaN output transfer → `flags = 000`.
